// File: rtl/wb_port_arbiter_if.sv
// Port bundle for wb_port_arbiter: writeback request, LU result handshake and RF write port.
// master drives requests and LU results (pipeline side); slave is the arbiter.
interface wb_port_arbiter_if #(
  parameter int DEPTH = 2
);
  logic                     pipe_write_en_in;
  logic [4:0]               pipe_write_addr_in;
  logic [31:0]              pipe_writedata_in;
  logic                     lu_valid;
  logic                     lu_ready;
  logic [4:0]               lu_write_addr;
  logic [31:0]              lu_writedata;
  logic                     reg_write_en;
  logic [4:0]               reg_write_addr;
  logic [31:0]              reg_writedata;
  logic                     wb_stall;
  logic [$clog2(DEPTH):0]   lu_pending;

  modport master (
    output pipe_write_en_in, pipe_write_addr_in, pipe_writedata_in,
    output lu_valid, lu_write_addr, lu_writedata,
    input  lu_ready, reg_write_en, reg_write_addr, reg_writedata,
    input  wb_stall, lu_pending
  );

  modport slave (
    input  pipe_write_en_in, pipe_write_addr_in, pipe_writedata_in,
    input  lu_valid, lu_write_addr, lu_writedata,
    output lu_ready, reg_write_en, reg_write_addr, reg_writedata,
    output wb_stall, lu_pending
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// RF write-port arbiter: writeback has priority, LU results queue in a DEPTH-entry FIFO (>=1 cycle latency, 0 with WB_LU_BYPASS_EN).
// Backpressure: lu_ready drops when the FIFO is full; a head blocked MAX_WAIT cycles raises wb_stall for one cycle.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_FIFO,
    SRC_BYP
  } src_e;

  logic [4:0]       mem_addr [DEPTH];
  logic [31:0]      mem_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic [AGE_W-1:0] age;
  logic             wb_stall_q;

  logic             empty;
  logic             full;
  logic             pipe_req;
  logic             push_hs;
  logic             lu_nonzero;
  logic             push_store;
  logic             pop;
  src_e             src;
  logic [AGE_W-1:0] age_d;
  logic             stall_d;

  assign empty      = (cnt == '0);
  assign full       = (cnt == CNT_FULL);
  assign pipe_req   = bus.pipe_write_en_in && (bus.pipe_write_addr_in != 5'd0);
  assign push_hs    = bus.lu_valid && !full;
  assign lu_nonzero = (bus.lu_write_addr != 5'd0);

  // Stall cycle belongs to the FIFO head; otherwise pipeline first, FIFO fills idle slots.
  always_comb begin
    src = SRC_NONE;
    if (wb_stall_q && !empty) begin
      src = SRC_FIFO;
    end else if (pipe_req) begin
      src = SRC_PIPE;
    end else if (!empty) begin
      src = SRC_FIFO;
`ifdef WB_LU_BYPASS_EN
    end else if (push_hs && lu_nonzero && !wb_stall_q) begin
      src = SRC_BYP;
`endif
    end
  end

  assign pop        = (src == SRC_FIFO);
  assign push_store = push_hs && lu_nonzero && (src != SRC_BYP);

  always_comb begin
    bus.reg_write_en   = 1'b0;
    bus.reg_write_addr = bus.pipe_write_addr_in;
    bus.reg_writedata  = bus.pipe_writedata_in;
    case (src)
      SRC_PIPE: begin
        bus.reg_write_en = 1'b1;
      end
      SRC_FIFO: begin
        bus.reg_write_en   = 1'b1;
        bus.reg_write_addr = mem_addr[rd_ptr];
        bus.reg_writedata  = mem_data[rd_ptr];
      end
      SRC_BYP: begin
        bus.reg_write_en   = 1'b1;
        bus.reg_write_addr = bus.lu_write_addr;
        bus.reg_writedata  = bus.lu_writedata;
      end
      default: begin
        bus.reg_write_en = 1'b0;
      end
    endcase
    if (rst) begin
      bus.reg_write_en = 1'b0;
    end
  end

  // Age only grows while a queued head loses to the pipeline; any pop or empty FIFO clears it.
  always_comb begin
    age_d   = '0;
    stall_d = 1'b0;
    if (!empty && (src == SRC_PIPE)) begin
      if (age == AGE_LAST) begin
        stall_d = 1'b1;
      end else begin
        age_d = age + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      age        <= '0;
      wb_stall_q <= 1'b0;
    end else begin
      if (push_store) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      cnt        <= cnt + CNT_W'(push_store) - CNT_W'(pop);
      age        <= age_d;
      wb_stall_q <= stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_store) begin
      mem_addr[wr_ptr] <= bus.lu_write_addr;
      mem_data[wr_ptr] <= bus.lu_writedata;
    end
  end

  assign bus.lu_ready   = !full;
  assign bus.wb_stall   = wb_stall_q;
  assign bus.lu_pending = cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based reference model feeds an expectation scoreboard checked by a monitor.
module tb_wb_port_arbiter;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DEPTH(DEPTH)) bus ();

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        en;
    bit [4:0]  addr;
    bit [31:0] data;
    bit        stall;
    bit        ready;
    int        pending;
  } exp_t;

  typedef struct {
    bit [4:0]  addr;
    bit [31:0] data;
  } ent_t;

  exp_t exp_q[$];
  ent_t m_q[$];
  int   m_age;
  bit   m_stall;
  bit   held_v;
  ent_t held;
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reg_write_en", bus.reg_write_en, e.en);
        if (e.en) begin
          chk("reg_write_addr", bus.reg_write_addr, e.addr);
          chk("reg_writedata", bus.reg_writedata, e.data);
        end
        chk("wb_stall", bus.wb_stall, e.stall);
        chk("lu_ready", bus.lu_ready, e.ready);
        chk("lu_pending", bus.lu_pending, e.pending);
      end
    end
  end

  task automatic drive_idle();
    bus.pipe_write_en_in   = 1'b0;
    bus.pipe_write_addr_in = 5'd0;
    bus.pipe_writedata_in  = 32'd0;
    bus.lu_valid           = 1'b0;
    bus.lu_write_addr      = 5'd0;
    bus.lu_writedata       = 32'd0;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_age   = 0;
    m_stall = 1'b0;
    held_v  = 1'b0;
    held.addr = 5'd0;
    held.data = 32'd0;
  endtask

  // One clock cycle: called just after a rising edge, returns just after the next one.
  task automatic cyc(input bit pe, input bit [4:0] pa, input bit [31:0] pd,
                     input bit nl, input bit [4:0] la, input bit [31:0] ld,
                     output bit stalled);
    exp_t e;
    bit   ready, acc, preq, pop, byp, nst;
    int   nage;
    if (nl && !held_v) begin
      held_v    = 1'b1;
      held.addr = la;
      held.data = ld;
    end
    bus.pipe_write_en_in   = pe;
    bus.pipe_write_addr_in = pa;
    bus.pipe_writedata_in  = pd;
    bus.lu_valid           = held_v;
    bus.lu_write_addr      = held.addr;
    bus.lu_writedata       = held.data;

    ready = (m_q.size() < DEPTH);
    acc   = held_v && ready;
    preq  = pe && (pa != 5'd0);
    pop = 1'b0; byp = 1'b0;
    e.en = 1'b0; e.addr = 5'd0; e.data = 32'd0;
    if (m_stall && m_q.size() > 0) begin
      e.en = 1'b1; e.addr = m_q[0].addr; e.data = m_q[0].data; pop = 1'b1;
    end else if (preq) begin
      e.en = 1'b1; e.addr = pa; e.data = pd;
    end else if (m_q.size() > 0) begin
      e.en = 1'b1; e.addr = m_q[0].addr; e.data = m_q[0].data; pop = 1'b1;
`ifdef WB_LU_BYPASS_EN
    end else if (acc && held.addr != 5'd0 && !m_stall) begin
      e.en = 1'b1; e.addr = held.addr; e.data = held.data; byp = 1'b1;
`endif
    end
    nst = 1'b0; nage = 0;
    if (m_q.size() > 0 && !pop && preq) begin
      if (m_age == MAX_WAIT - 1) nst = 1'b1;
      else nage = m_age + 1;
    end
    e.stall   = m_stall;
    e.ready   = ready;
    e.pending = m_q.size();
    exp_q.push_back(e);
    stalled = m_stall;

    @(posedge clk);
    #1;
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      if (held.addr != 5'd0 && !byp) m_q.push_back(held);
      held_v = 1'b0;
    end
    m_stall = nst;
    m_age   = nage;
  endtask

  // Pipeline write that is re-presented while the pipeline is frozen.
  task automatic pw(input bit pe, input bit [4:0] pa, input bit [31:0] pd,
                    input bit nl, input bit [4:0] la, input bit [31:0] ld);
    bit st;
    cyc(pe, pa, pd, nl, la, ld, st);
    while (st) cyc(pe, pa, pd, 1'b0, 5'd0, 32'd0, st);
  endtask

  initial begin
    bit        st;
    bit        pe, nl;
    bit [4:0]  pa, la;
    bit [31:0] pd, ld;
    checks = 0;
    errors = 0;
    model_reset();
    drive_idle();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Reset state and idle drain of x5.
    pw(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    pw(0, 5'd0, 32'd0, 1, 5'd5, 32'hDEADBEEF);
    repeat (2) pw(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Pipe priority with LU filling the FIFO.
    for (int i = 1; i <= 8; i++)
      pw(1, 5'(i), 32'h100 + 32'(i), i <= 3, 5'(9 + i), 32'hA000 + 32'(i));
    repeat (5) pw(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Starvation with pipe held high.
    pw(1, 5'd20, 32'h2020, 1, 5'd9, 32'h9999);
    for (int i = 0; i < 7; i++) pw(1, 5'd21 + 5'(i % 3), 32'h3000 + 32'(i), 0, 5'd0, 32'd0);
    repeat (3) pw(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // x0 handling.
    pw(1, 5'd3, 32'h333, 1, 5'd7, 32'h7777);
    pw(1, 5'd0, 32'h555, 0, 5'd0, 32'd0);
    pw(0, 5'd0, 32'd0, 1, 5'd0, 32'h1234);
    pw(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Pointer wrap with back-to-back push/pop.
    for (int i = 0; i < 20; i++) pw(0, 5'd0, 32'd0, 1, 5'(1 + i), $urandom);
    repeat (2) pw(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Asynchronous reset with two entries queued.
    pw(1, 5'd2, 32'h22, 1, 5'd10, 32'hAAAA);
    pw(1, 5'd2, 32'h23, 1, 5'd11, 32'hBBBB);
    bus.pipe_write_en_in   = 1'b1;
    bus.pipe_write_addr_in = 5'd4;
    #2 rst = 1'b1;
    #1;
    chk("rst_reg_write_en", bus.reg_write_en, 1'b0);
    chk("rst_wb_stall", bus.wb_stall, 1'b0);
    chk("rst_lu_pending", bus.lu_pending, 0);
    model_reset();
    drive_idle();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    pw(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

    // Randomized traffic.
    st = 1'b0;
    pe = 1'b0; pa = 5'd0; pd = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      if (!st) begin
        pe = ($urandom_range(0, 9) < 6);
        pa = 5'($urandom_range(0, 31));
        pd = $urandom;
      end
      nl = ($urandom_range(0, 9) < 4);
      la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ld = $urandom;
      cyc(pe, pa, pd, nl, la, ld, st);
    end
    drive_idle();
    @(negedge clk);
    chk("expectations_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
